mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Parametrised successor to the pipeline Memory stage. Sits between EX/MEM and MEM/WB.
- Adds byte/half/word loads and stores with sign/zero extension, and full RV32 branch resolution from ALU compare flags.
- Adds configurable data-memory wait states via a stall handshake, plus misalignment detection.
- Registers all writeback outputs.

Parameters:
XLEN, 32, datapath width (32 only; kept for package symmetry)
DEPTH, 256, data memory depth in XLEN words (power of two)
WAIT_STATES, 0, extra stall cycles per load/store (0..7)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset (port keeps codebase name; asserted at 0)
valid_in  in  1  EX/MEM slot holds a real instruction
flush_in  in  1  kill current slot
Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in, Ctl_Branch_in, Ctl_Jump_in  in  1 each  control bits
funct3_in  in  3  access size/sign for load/store; compare mode for branch
Rd_in  in  5  destination register
Zero_in, Lt_in, Ltu_in  in  1 each  ALU flags: equal, signed less, unsigned less
Write_Data  in  XLEN  store data (rs2)
ALUresult_in  in  XLEN  effective address or ALU result
PCimm_in  in  XLEN  branch/jump target
stall_out  out  1  hold upstream; EX/MEM inputs must stay stable while high
PCSrc  out  1  take PCimm_out (combinational)
PCimm_out  out  XLEN  = PCimm_in (combinational)
Ctl_MemtoReg_out, Ctl_RegWrite_out  out  1 each  registered
Rd_out  out  5  registered
Read_Data  out  XLEN  registered, extended load data
ALUresult_out  out  XLEN  registered
misalign_out  out  1  registered, one cycle per faulting access

Behaviour:
- Reset (reset==0, async): all registered outputs 0, FSM IDLE, wait counter 0. Memory array is not reset.
- Branch is combinational: PCSrc = valid_in & ~flush_in & (Ctl_Jump_in | (Ctl_Branch_in & cond)).
  - cond by funct3: 000 Zero, 001 ~Zero, 100 Lt, 101 ~Lt, 110 Ltu, 111 ~Ltu, 010/011 → 0.
  - PCSrc is independent of stall state.
- Access = valid_in & (MemRead|MemWrite) & ~flush_in. Word index = ALUresult_in[log2(DEPTH)+1:2]; higher address bits ignored (wrap).
- Sizes by funct3[1:0]: 00 byte, 01 half, 10 word.
  - Store lanes select by addr[1:0], data replicated from Write_Data low bits.
  - Load: funct3[2]=1 zero-extends, else sign-extends. Loads read asynchronously from the array and are captured into Read_Data.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0. No memory write; misalign_out=1 and Ctl_RegWrite_out=0 for that slot.
- FSM:
  - IDLE: on an access with WAIT_STATES>0, go to WAIT, counter=WAIT_STATES, stall_out=1.
  - WAIT: counter decrements each cycle; stall_out stays 1 until counter reaches 1.
  - Completion: on the cycle counter==1 (or immediately if WAIT_STATES=0), stall_out=0, the store commits at that edge, and MEM/WB captures. Then return to IDLE.
- MEM/WB register: captures on every edge where stall_out=0. While stall_out=1 it loads a bubble (RegWrite_out=0, MemtoReg_out=0, misalign_out=0).
- flush_in: bubble is captured next edge; FSM aborts to IDLE without committing the store.
- Store/load latency is WAIT_STATES+1 edges from the first presentation.
- Back-to-back accesses are legal: the next access starts in IDLE on the cycle after completion.

Decomposition:
- Package mem_pkg: funct3 encodings (size, branch modes), FSM state enum, XLEN.
- One sub-module, dmem_byte_ram: DEPTH×XLEN array with byte-enable write, async read.

Test Plan:
- WAIT_STATES=0: sw 0x12345678 @ addr 16, then lw @ 16 → next cycle Read_Data=0x12345678, MemtoReg_out=1.
- sb 0x80 @ addr 17, then lb @ 17 → 0xFFFFFF80; lbu @ 17 → 0x00000080; lhu @ 16 → 0x00008078.
- Branch sweep with Ctl_Branch_in=1 and PCimm_in=32:
  - beq with Zero=1 → PCSrc=1, PCimm_out=32.
  - blt with Lt=0 → 0.
  - bgeu with Ltu=0 → 1.
  - funct3=010 → 0.
- WAIT_STATES=3: lw → stall_out high exactly 3 cycles, three bubbles with RegWrite_out=0, data valid on the 4th edge.
- lw @ addr 6 with RegWrite_in=1 → misalign_out=1 for 1 cycle, RegWrite_out=0; sw @ 2 leaves memory unchanged.
- WAIT_STATES=3: sw in flight, drive reset=0 mid-WAIT → outputs 0 immediately, stall_out=0, word unchanged. Repeat the sw with flush_in at cycle 2 → same result.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory-stage load/store unit.
package mem_pkg;
  localparam int XLEN = 32;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic {ST_IDLE, ST_WAIT} lsu_state_e;
endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised data RAM with per-byte write enables and combinational read.
module dmem_byte_ram import mem_pkg::*; #(
  parameter int XLEN  = mem_pkg::XLEN,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic [XLEN/8-1:0]        i_be,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [XLEN-1:0]          i_wdata,
  output logic [XLEN-1:0]          o_rdata
);
  logic [XLEN-1:0] r_mem [DEPTH];

  always_ff @(posedge clk)
    for (int b = 0; b < XLEN/8; b++)
      if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/mem_stage_lsu.sv
// Pipeline memory stage: branch resolve, sized loads/stores with wait states, MEM/WB register.
module mem_stage_lsu import mem_pkg::*; #(
  parameter int XLEN        = mem_pkg::XLEN,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic            flush_in,
  input  logic            Ctl_MemtoReg_in,
  input  logic            Ctl_RegWrite_in,
  input  logic            Ctl_MemRead_in,
  input  logic            Ctl_MemWrite_in,
  input  logic            Ctl_Branch_in,
  input  logic            Ctl_Jump_in,
  input  logic [2:0]      funct3_in,
  input  logic [4:0]      Rd_in,
  input  logic            Zero_in,
  input  logic            Lt_in,
  input  logic            Ltu_in,
  input  logic [XLEN-1:0] Write_Data,
  input  logic [XLEN-1:0] ALUresult_in,
  input  logic [XLEN-1:0] PCimm_in,
  output logic            stall_out,
  output logic            PCSrc,
  output logic [XLEN-1:0] PCimm_out,
  output logic            Ctl_MemtoReg_out,
  output logic            Ctl_RegWrite_out,
  output logic [4:0]      Rd_out,
  output logic [XLEN-1:0] Read_Data,
  output logic [XLEN-1:0] ALUresult_out,
  output logic            misalign_out
);
  localparam int         AW = $clog2(DEPTH);
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  lsu_state_e          r_state;
  logic [2:0]          r_cnt;
  logic                w_slot, w_access, w_mis, w_cond;
  logic [1:0]          w_off, w_size;
  logic [XLEN/8-1:0]   w_be, w_we;
  logic [XLEN-1:0]     w_wdata, w_rdata, w_ldata;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic                w_unused;

  assign w_unused = ^ALUresult_in[XLEN-1:AW+2];
  assign w_off    = ALUresult_in[1:0];
  assign w_size   = funct3_in[1:0];
  assign w_slot   = valid_in & ~flush_in;
  assign w_access = w_slot & (Ctl_MemRead_in | Ctl_MemWrite_in);

  always_comb begin
    w_cond = 1'b0;
    case (funct3_in)
      BR_EQ:   w_cond = Zero_in;
      BR_NE:   w_cond = ~Zero_in;
      BR_LT:   w_cond = Lt_in;
      BR_GE:   w_cond = ~Lt_in;
      BR_LTU:  w_cond = Ltu_in;
      BR_GEU:  w_cond = ~Ltu_in;
      default: w_cond = 1'b0;
    endcase
  end
  assign PCSrc     = w_slot & (Ctl_Jump_in | (Ctl_Branch_in & w_cond));
  assign PCimm_out = PCimm_in;

  // Gated by reset so a pending access never holds upstream while in reset.
  assign stall_out = reset & w_access &
                     ((r_state == ST_IDLE) ? (WS != 3'd0) : (r_cnt != 3'd1));

  always_comb begin
    w_be    = '1;
    w_wdata = Write_Data;
    w_mis   = (w_off != 2'b00);
    case (w_size)
      SZ_B: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{Write_Data[7:0]}};
        w_mis   = 1'b0;
      end
      SZ_H: begin
        w_be    = 4'b0011 << {w_off[1], 1'b0};
        w_wdata = {2{Write_Data[15:0]}};
        w_mis   = w_off[0];
      end
      default: ;
    endcase
  end

  // Stores commit only on the completing (non-stalled) edge.
  assign w_we = (reset & w_access & Ctl_MemWrite_in & ~w_mis & ~stall_out) ? w_be : '0;

  dmem_byte_ram #(.XLEN(XLEN), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .i_be    (w_we),
    .i_addr  (ALUresult_in[AW+1:2]),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  assign w_byte = w_rdata[{w_off, 3'b000} +: 8];
  assign w_half = w_rdata[{w_off[1], 4'b0000} +: 16];

  always_comb begin
    case (w_size)
      SZ_B:    w_ldata = funct3_in[2] ? {{(XLEN-8){1'b0}}, w_byte}
                                      : {{(XLEN-8){w_byte[7]}}, w_byte};
      SZ_H:    w_ldata = funct3_in[2] ? {{(XLEN-16){1'b0}}, w_half}
                                      : {{(XLEN-16){w_half[15]}}, w_half};
      default: w_ldata = w_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE:
          if (w_access && WS != 3'd0) begin
            r_state <= ST_WAIT;
            r_cnt   <= WS;
          end
        ST_WAIT:
          if (!w_access || r_cnt == 3'd1) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Ctl_MemtoReg_out <= 1'b0;
      Ctl_RegWrite_out <= 1'b0;
      misalign_out     <= 1'b0;
      Rd_out           <= '0;
      Read_Data        <= '0;
      ALUresult_out    <= '0;
    end else if (stall_out) begin
      Ctl_MemtoReg_out <= 1'b0;
      Ctl_RegWrite_out <= 1'b0;
      misalign_out     <= 1'b0;
    end else begin
      Ctl_MemtoReg_out <= w_slot & Ctl_MemtoReg_in;
      Ctl_RegWrite_out <= w_slot & Ctl_RegWrite_in & ~(w_access & w_mis);
      misalign_out     <= w_access & w_mis;
      Rd_out           <= Rd_in;
      Read_Data        <= w_ldata;
      ALUresult_out    <= ALUresult_in;
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: a zero-wait and a three-wait instance against a byte-array memory model.
module tb_mem_stage_lsu;
  logic clk = 1'b0;
  logic reset;
  logic valid0, valid3, flush_in, mtr, rw, mr, mw, br, jp, zero, lt, ltu;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [31:0] wd, alu, pcimm;

  logic        stall0, pcsrc0, mtr0, rw0, mis0, stall3, pcsrc3, mtr3, rw3, mis3;
  logic [4:0]  rdo0, rdo3;
  logic [31:0] pco0, rdat0, aluo0, pco3, rdat3, aluo3;

  int tests = 0, fails = 0;
  logic [7:0] bm [2][1024];

  localparam logic [2:0] BF3 [4] = '{3'b000, 3'b100, 3'b111, 3'b010};
  localparam logic [2:0] BFL [4] = '{3'b100, 3'b000, 3'b000, 3'b111};
  localparam logic       BEX [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [2:0] LDF [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  always #5 clk = ~clk;

  mem_stage_lsu #(.DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .valid_in(valid0), .flush_in(flush_in),
    .Ctl_MemtoReg_in(mtr), .Ctl_RegWrite_in(rw), .Ctl_MemRead_in(mr), .Ctl_MemWrite_in(mw),
    .Ctl_Branch_in(br), .Ctl_Jump_in(jp), .funct3_in(f3), .Rd_in(rd),
    .Zero_in(zero), .Lt_in(lt), .Ltu_in(ltu), .Write_Data(wd), .ALUresult_in(alu), .PCimm_in(pcimm),
    .stall_out(stall0), .PCSrc(pcsrc0), .PCimm_out(pco0), .Ctl_MemtoReg_out(mtr0),
    .Ctl_RegWrite_out(rw0), .Rd_out(rdo0), .Read_Data(rdat0), .ALUresult_out(aluo0),
    .misalign_out(mis0));

  mem_stage_lsu #(.DEPTH(256), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .valid_in(valid3), .flush_in(flush_in),
    .Ctl_MemtoReg_in(mtr), .Ctl_RegWrite_in(rw), .Ctl_MemRead_in(mr), .Ctl_MemWrite_in(mw),
    .Ctl_Branch_in(br), .Ctl_Jump_in(jp), .funct3_in(f3), .Rd_in(rd),
    .Zero_in(zero), .Lt_in(lt), .Ltu_in(ltu), .Write_Data(wd), .ALUresult_in(alu), .PCimm_in(pcimm),
    .stall_out(stall3), .PCSrc(pcsrc3), .PCimm_out(pco3), .Ctl_MemtoReg_out(mtr3),
    .Ctl_RegWrite_out(rw3), .Rd_out(rdo3), .Read_Data(rdat3), .ALUresult_out(aluo3),
    .misalign_out(mis3));

  // Reference memory: little-endian byte array, address taken modulo the 1 KiB footprint.
  function automatic int nb(input logic [2:0] f);
    return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit misal(input logic [2:0] f, input logic [31:0] a);
    return (a % nb(f)) != 0;
  endfunction

  task automatic mstore(input int k, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    if (!misal(f, a))
      for (int i = 0; i < nb(f); i++) bm[k][(a + i) % 1024] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] mload(input int k, input logic [2:0] f, input logic [31:0] a);
    logic [31:0] v;
    int n;
    v = 0;
    n = nb(f);
    for (int i = 0; i < n; i++) v = v | (32'(bm[k][(a + i) % 1024]) << (8*i));
    if (!f[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    valid0 = 0; valid3 = 0; flush_in = 0; mtr = 0; rw = 0; mr = 0; mw = 0; br = 0; jp = 0;
    f3 = 0; rd = 0; zero = 0; lt = 0; ltu = 0; wd = 0; alu = 0; pcimm = 0;
  endtask

  task automatic mem_in(input bit inst3, input bit ld, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    idle_in;
    valid0 = !inst3; valid3 = inst3;
    mr = ld; mw = !ld; mtr = ld; rw = ld;
    f3 = f; alu = a; wd = d; rd = r;
  endtask

  task automatic test_reset;
    idle_in;
    reset = 0;
    tick; tick;
    tests++; if ({rw0, mtr0, mis0, rdo0, rdat0, aluo0} !== '0)
      begin fails++; $display("FAIL reset_ws0: got %h want 0", {rw0, mtr0, mis0, rdo0, rdat0, aluo0}); end
    tests++; if ({rw3, mtr3, mis3, rdo3, rdat3, aluo3} !== '0)
      begin fails++; $display("FAIL reset_ws3: got %h want 0", {rw3, mtr3, mis3, rdo3, rdat3, aluo3}); end
    tests++; if ({stall0, stall3} !== 2'b00)
      begin fails++; $display("FAIL reset_stall: got %b want 00", {stall0, stall3}); end
    reset = 1;
    tick;
  endtask

  task automatic test_word;
    mem_in(0, 0, 3'b010, 32'd16, 32'h1234_5678, 5'd3);
    mstore(0, 3'b010, 32'd16, 32'h1234_5678);
    tick;
    tests++; if ({rw0, mtr0, mis0} !== 3'b000)
      begin fails++; $display("FAIL sw_wb: got %b want 000", {rw0, mtr0, mis0}); end
    mem_in(0, 1, 3'b010, 32'd16, 32'h0, 5'd7);
    tick;
    tests++; if (rdat0 !== 32'h1234_5678)
      begin fails++; $display("FAIL lw_data: got %h want 12345678", rdat0); end
    tests++; if ({mtr0, rw0, rdo0} !== {1'b1, 1'b1, 5'd7})
      begin fails++; $display("FAIL lw_ctl: got %b want 1100111", {mtr0, rw0, rdo0}); end
    idle_in;
  endtask

  task automatic test_byte;
    mem_in(0, 0, 3'b000, 32'd17, 32'hABCD_EF80, 5'd0);
    mstore(0, 3'b000, 32'd17, 32'hABCD_EF80);
    tick;
    mem_in(0, 1, 3'b000, 32'd17, 0, 5'd1); tick;
    tests++; if (rdat0 !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb: got %h want ffffff80", rdat0); end
    mem_in(0, 1, 3'b100, 32'd17, 0, 5'd1); tick;
    tests++; if (rdat0 !== 32'h0000_0080) begin fails++; $display("FAIL lbu: got %h want 00000080", rdat0); end
    mem_in(0, 1, 3'b101, 32'd16, 0, 5'd1); tick;
    tests++; if (rdat0 !== 32'h0000_8078) begin fails++; $display("FAIL lhu: got %h want 00008078", rdat0); end
    mem_in(0, 1, 3'b001, 32'd16, 0, 5'd1); tick;
    tests++; if (rdat0 !== 32'hFFFF_8078) begin fails++; $display("FAIL lh: got %h want ffff8078", rdat0); end
    idle_in;
  endtask

  task automatic test_branch;
    logic c, e;
    for (int i = 0; i < 4; i++) begin
      idle_in;
      valid0 = 1; br = 1; pcimm = 32'd32; f3 = BF3[i];
      {zero, lt, ltu} = BFL[i];
      #1;
      tests++; if ({pcsrc0, pco0} !== {BEX[i], 32'd32})
        begin fails++; $display("FAIL branch_tbl%0d: got %b/%h want %b/%h", i, pcsrc0, pco0, BEX[i], 32'd32); end
    end
    for (int i = 0; i < 40; i++) begin
      idle_in;
      valid0 = 1'($urandom); flush_in = ($urandom_range(0, 3) == 0);
      br = 1'($urandom); jp = ($urandom_range(0, 3) == 0);
      f3 = 3'($urandom); {zero, lt, ltu} = 3'($urandom); pcimm = $urandom;
      case (f3)
        3'd0: c = zero;   3'd1: c = !zero;
        3'd4: c = lt;     3'd5: c = !lt;
        3'd6: c = ltu;    3'd7: c = !ltu;
        default: c = 1'b0;
      endcase
      e = valid0 && !flush_in && (jp || (br && c));
      #1;
      tests++; if ({pcsrc0, pco0} !== {e, pcimm})
        begin fails++; $display("FAIL branch_rand%0d: got %b/%h want %b/%h", i, pcsrc0, pco0, e, pcimm); end
    end
    idle_in;
    tick;
  endtask

  task automatic test_random;
    logic [31:0] a, d, ev;
    logic [2:0]  f;
    bit ld, em;
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      mem_in(0, 0, 3'b010, 32'(w * 4), d, 5'd0);
      mstore(0, 3'b010, 32'(w * 4), d);
      tick;
    end
    for (int i = 0; i < 80; i++) begin
      ld = 1'($urandom);
      f  = ld ? LDF[$urandom_range(0, 4)] : LDF[$urandom_range(0, 2)];
      a  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      d  = $urandom;
      em = misal(f, a);
      ev = 0;
      if (ld) ev = mload(0, f, a);
      else    mstore(0, f, a, d);
      mem_in(0, ld, f, a, d, 5'($urandom_range(1, 31)));
      tick;
      tests++; if ({mis0, rw0} !== {em, ld && !em})
        begin fails++; $display("FAIL rand%0d_ctl: got %b want %b (f3=%b a=%h)", i, {mis0, rw0}, {em, ld && !em}, f, a); end
      tests++; if ({stall0, aluo0} !== {1'b0, a})
        begin fails++; $display("FAIL rand%0d_alu: got %h want %h", i, {stall0, aluo0}, {1'b0, a}); end
      if (ld && !em) begin
        tests++; if (rdat0 !== ev)
          begin fails++; $display("FAIL rand%0d_load: got %h want %h (f3=%b a=%h)", i, rdat0, ev, f, a); end
      end
    end
    idle_in;
  endtask

  task automatic test_misalign;
    logic [31:0] ev;
    mem_in(0, 1, 3'b010, 32'd6, 0, 5'd5);
    tick;
    tests++; if ({mis0, rw0} !== 2'b10)
      begin fails++; $display("FAIL mis_lw: got %b want 10", {mis0, rw0}); end
    idle_in;
    tick;
    tests++; if (mis0 !== 1'b0)
      begin fails++; $display("FAIL mis_pulse: got %b want 0", mis0); end
    ev = mload(0, 3'b010, 32'd0);
    mem_in(0, 0, 3'b010, 32'd2, ~ev, 5'd0);
    tick;
    tests++; if (mis0 !== 1'b1)
      begin fails++; $display("FAIL mis_sw: got %b want 1", mis0); end
    mem_in(0, 1, 3'b010, 32'd0, 0, 5'd4);
    tick;
    tests++; if (rdat0 !== ev)
      begin fails++; $display("FAIL mis_sw_nowrite: got %h want %h", rdat0, ev); end
    idle_in;
  endtask

  task automatic test_wait3;
    logic [31:0] v;
    v = $urandom;
    mem_in(1, 0, 3'b010, 32'd32, v, 5'd0);
    mstore(1, 3'b010, 32'd32, v);
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (stall3 !== (i < 3))
        begin fails++; $display("FAIL ws3_sw_stall%0d: got %b want %b", i, stall3, i < 3); end
      tick;
    end
    mem_in(1, 1, 3'b010, 32'd32, 0, 5'd9);
    jp = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if ({stall3, pcsrc3} !== {i < 3, 1'b1})
        begin fails++; $display("FAIL ws3_lw_stall%0d: got %b want %b", i, {stall3, pcsrc3}, {i < 3, 1'b1}); end
      tick;
      if (i < 3) begin
        tests++; if ({rw3, mtr3} !== 2'b00)
          begin fails++; $display("FAIL ws3_bubble%0d: got %b want 00", i, {rw3, mtr3}); end
      end
    end
    tests++; if ({rdat3, rw3, mtr3, rdo3} !== {mload(1, 3'b010, 32'd32), 1'b1, 1'b1, 5'd9})
      begin fails++; $display("FAIL ws3_lw_data: got %h want %h", {rdat3, rw3, mtr3, rdo3},
                              {mload(1, 3'b010, 32'd32), 1'b1, 1'b1, 5'd9}); end
    idle_in;
  endtask

  task automatic test_reset_mid;
    logic [31:0] ev;
    ev = mload(1, 3'b010, 32'd32);
    mem_in(1, 0, 3'b010, 32'd32, ~ev, 5'd0);
    tick; tick;
    reset = 0;
    #1;
    tests++; if (stall3 !== 1'b0)
      begin fails++; $display("FAIL rstmid_stall: got %b want 0", stall3); end
    tests++; if ({rw3, mtr3, mis3, rdo3, rdat3, aluo3} !== '0)
      begin fails++; $display("FAIL rstmid_regs: got %h want 0", {rw3, mtr3, mis3, rdo3, rdat3, aluo3}); end
    tick; tick;
    idle_in;
    reset = 1;
    tick;
    mem_in(1, 1, 3'b010, 32'd32, 0, 5'd2);
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (stall3 !== (i < 3))
        begin fails++; $display("FAIL rstmid_lw_stall%0d: got %b want %b", i, stall3, i < 3); end
      tick;
    end
    tests++; if (rdat3 !== ev)
      begin fails++; $display("FAIL rstmid_unchanged: got %h want %h", rdat3, ev); end
    idle_in;
  endtask

  task automatic test_flush;
    logic [31:0] ev;
    ev = mload(1, 3'b010, 32'd32);
    mem_in(1, 0, 3'b010, 32'd32, ~ev, 5'd0);
    tick; tick;
    flush_in = 1;
    #1;
    tests++; if (stall3 !== 1'b0)
      begin fails++; $display("FAIL flush_stall: got %b want 0", stall3); end
    tick;
    tests++; if ({rw3, mtr3, mis3} !== 3'b000)
      begin fails++; $display("FAIL flush_bubble: got %b want 000", {rw3, mtr3, mis3}); end
    mem_in(1, 1, 3'b010, 32'd32, 0, 5'd6);
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (stall3 !== (i < 3))
        begin fails++; $display("FAIL flush_lw_stall%0d: got %b want %b", i, stall3, i < 3); end
      tick;
    end
    tests++; if ({rdat3, rw3} !== {ev, 1'b1})
      begin fails++; $display("FAIL flush_unchanged: got %h want %h", {rdat3, rw3}, {ev, 1'b1}); end
    idle_in;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_branch;
    test_random;
    test_misalign;
    test_wait3;
    test_reset_mid;
    test_flush;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
